vga_pattern_gen: RTL

Pixel-colour stage directly downstream of the VGA timing generator. Consumes its per-pixel `disp_ena`/`n_blank`/`n_sync`/`col`/`row` stream and produces 4-bit-per-channel RGB with the control signals delayed to match. Selects one of four test patterns, including a bouncing box whose position advances once per frame. Mode changes are requested through a handshake and take effect only at a frame boundary, so no frame is ever torn.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_box_tracker.sv | 58 +++++
 rtl/vga_pattern_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern generator and its box tracker.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 300;
    localparam int unsigned DEF_V_ACTIVE = 150;
    localparam int unsigned COL_W        = 9;
    localparam int unsigned ROW_W        = 8;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    // Per-bar {r,g,b} enables; index 0 is the leftmost (white) bar.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    typedef struct packed {
        logic             de;
        logic             nb;
        logic             ns;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } pix_t;

    // Idle pixel: blanked, sync deasserted (n_sync high).
    localparam pix_t PIX_IDLE = '{de: 1'b0, nb: 1'b0, ns: 1'b1, col: '0, row: '0};

    // One bounce step along an axis; returns {moving_forward, new_pos}.
    function automatic logic [COL_W:0] bounce_step(
        input logic [COL_W-1:0] pos,
        input logic             fwd,
        input logic [COL_W-1:0] lim
    );
        logic             fwd_n;
        logic [COL_W-1:0] pos_n;
        fwd_n = fwd;
        if (fwd && (pos == lim)) begin
            fwd_n = 1'b0;
            pos_n = pos - COL_W'(1);
        end else if (!fwd && (pos == '0)) begin
            fwd_n = 1'b1;
            pos_n = pos + COL_W'(1);
        end else begin
            pos_n = fwd ? (pos + COL_W'(1)) : (pos - COL_W'(1));
        end
        return {fwd_n, pos_n};
    endfunction

endpackage

// File: rtl/vga_box_tracker.sv
// Bouncing-box position state; advances one pixel per axis on each step strobe.
module vga_box_tracker
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned BOX      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [COL_W-1:0] box_x,
    output logic [ROW_W-1:0] box_y
);

    localparam logic [COL_W-1:0] X_LIM = COL_W'(H_ACTIVE - BOX);
    localparam logic [COL_W-1:0] Y_LIM = COL_W'(V_ACTIVE - BOX);

    logic [COL_W-1:0] box_x_q, box_x_d;
    logic [ROW_W-1:0] box_y_q, box_y_d;
    logic             dx_q, dx_d;
    logic             dy_q, dy_d;
    logic [COL_W:0]   x_nxt;
    logic [COL_W:0]   y_nxt;

    always_comb begin
        x_nxt   = bounce_step(box_x_q, dx_q, X_LIM);
        y_nxt   = bounce_step(COL_W'(box_y_q), dy_q, Y_LIM);
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        if (step) begin
            dx_d    = x_nxt[COL_W];
            box_x_d = x_nxt[COL_W-1:0];
            dy_d    = y_nxt[COL_W];
            box_y_d = ROW_W'(y_nxt[COL_W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign box_x = box_x_q;
    assign box_y = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind the VGA timing generator. Mode and box position change only
// at frame start, and the frame-start pixel itself already uses the new values.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned BOX      = 16,
    parameter int unsigned CW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_ena,
    input  logic             n_blank,
    input  logic             n_sync,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic             mode_req,
    input  logic [1:0]       mode_in,
    output logic             mode_ack,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             disp_ena_o,
    output logic             n_blank_o,
    output logic             n_sync_o,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned      BAR_W = H_ACTIVE / 8;
    localparam logic [COL_W:0]   BOX_W = (COL_W + 1)'(BOX);
    localparam logic [ROW_W:0]   BOX_H = (ROW_W + 1)'(BOX);

    pix_t              s1_q, s1_d;
    pix_t              s2_q, s2_d;
    logic              de_prev_q, de_prev_d;
    logic              req_q, req_d;
    logic [1:0]        mode_in_q, mode_in_d;
    logic [2:0]        bar_q, bar_d;
    logic              chk_q, chk_d;
    mode_t             mode_q, mode_d;
    logic              ack_q, ack_d;
    logic [15:0]       frame_q, frame_d;
    logic [3*CW-1:0]   rgb_q, rgb_d;
    logic [2:0]        ctl_q, ctl_d;

    logic              fs;
    logic              hit;
    logic [COL_W-1:0]  bar_div;
    logic [2:0]        bar_en;
    logic [COL_W-1:0]  box_x;
    logic [ROW_W-1:0]  box_y;

    vga_box_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX      (BOX)
    ) u_box (
        .clk   (clk),
        .rst   (rst),
        .step  (fs),
        .box_x (box_x),
        .box_y (box_y)
    );

    // Stage 1: registered inputs -> frame-start detect and position-only pattern terms.
    always_comb begin
        s1_d      = '{de: disp_ena, nb: n_blank, ns: n_sync, col: col, row: row};
        req_d     = mode_req;
        mode_in_d = mode_in;
        de_prev_d = s1_q.de;
        fs        = s1_q.de && (s1_q.col == '0) && (s1_q.row == '0) && !de_prev_q;
        bar_div   = s1_q.col / COL_W'(BAR_W);
        bar_d     = (bar_div > COL_W'(7)) ? 3'd7 : bar_div[2:0];
        chk_d     = s1_q.col[4] ^ s1_q.row[4];
        s2_d      = s1_q;
        mode_d    = mode_q;
        if (fs && req_q) begin
            mode_d = mode_t'(mode_in_q);
        end
        ack_d     = fs && req_q;
        frame_d   = frame_q + 16'(fs);
    end

    // Stage 2: mode and box were updated on the same edge the FS pixel entered this stage.
    always_comb begin
        hit = ({1'b0, s2_q.col} >= {1'b0, box_x}) &&
              ({1'b0, s2_q.col} <  ({1'b0, box_x} + BOX_W)) &&
              ({1'b0, s2_q.row} >= {1'b0, box_y}) &&
              ({1'b0, s2_q.row} <  ({1'b0, box_y} + BOX_H));
        bar_en = BAR_RGB[bar_q];
        rgb_d  = '0;
        if (s2_q.de) begin
            unique case (mode_q)
                MODE_BLACK: rgb_d = '0;
                MODE_BARS:  rgb_d = {{CW{bar_en[2]}}, {CW{bar_en[1]}}, {CW{bar_en[0]}}};
                MODE_CHECK: rgb_d = {(3 * CW){chk_q}};
                MODE_BOX:   rgb_d = hit ? {(3 * CW){1'b1}} : {{(2 * CW){1'b0}}, {CW{1'b1}}};
                default:    rgb_d = '0;
            endcase
        end
        ctl_d = {s2_q.de, s2_q.nb, s2_q.ns};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= PIX_IDLE;
            s2_q      <= PIX_IDLE;
            de_prev_q <= 1'b0;
            req_q     <= 1'b0;
            mode_in_q <= '0;
            bar_q     <= '0;
            chk_q     <= 1'b0;
            mode_q    <= MODE_BLACK;
            ack_q     <= 1'b0;
            frame_q   <= '0;
            rgb_q     <= '0;
            ctl_q     <= 3'b001;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            de_prev_q <= de_prev_d;
            req_q     <= req_d;
            mode_in_q <= mode_in_d;
            bar_q     <= bar_d;
            chk_q     <= chk_d;
            mode_q    <= mode_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
            rgb_q     <= rgb_d;
            ctl_q     <= ctl_d;
        end
    end

    assign {red, green, blue}                = rgb_q;
    assign {disp_ena_o, n_blank_o, n_sync_o} = ctl_q;
    assign mode_ack                          = ack_q;
    assign frame_cnt                         = frame_q;

endmodule
